// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lsu_pkg
// Purpose  : Shared state encoding, access-size codes and legality helper
//            for the load/store unit.
// Revision : 1.0
// ============================================================================
package lsu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD    = 3'd1,
        ST_LATCH = 3'd2,
        ST_WR    = 3'd3,
        ST_RESP  = 3'd4
    } lsu_state_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    // Reserved size or an address not aligned to the access size.
    function automatic logic req_is_illegal(input logic [1:0] size,
                                            input logic [1:0] offset);
        logic illegal;
        case (size)
            SIZE_BYTE: illegal = 1'b0;
            SIZE_HALF: illegal = offset[0];
            SIZE_WORD: illegal = (offset != 2'b00);
            default:   illegal = 1'b1;
        endcase
        return illegal;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module   : lsu_align
// Purpose  : Big-endian sub-word extraction/extension for loads and
//            read-modify-write merging for stores (combinational).
// Revision : 1.0
// ============================================================================
module lsu_align (
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [1:0]  offset,
    input  logic [31:0] mem_word,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic [31:0] merged_word
);
    import lsu_pkg::*;

    logic [4:0]  w_shift;
    logic [31:0] w_mask;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_shift   = 5'd0;
        w_mask    = 32'hFFFF_FFFF;
        w_byte    = 8'h00;
        w_half    = 16'h0000;
        load_data = mem_word;
        case (size)
            SIZE_BYTE: begin
                // Offset 0 is the most significant byte: shift = (3 - offset) * 8.
                w_shift   = {~offset, 3'b000};
                w_byte    = 8'(mem_word >> w_shift);
                w_mask    = 32'h0000_00FF << w_shift;
                load_data = is_unsigned ? {24'h000000, w_byte}
                                        : {{24{w_byte[7]}}, w_byte};
            end
            SIZE_HALF: begin
                w_shift   = {~offset[1], 4'b0000};
                w_half    = 16'(mem_word >> w_shift);
                w_mask    = 32'h0000_FFFF << w_shift;
                load_data = is_unsigned ? {16'h0000, w_half}
                                        : {{16{w_half[15]}}, w_half};
            end
            default: ;
        endcase
        merged_word = (mem_word & ~w_mask) | ((store_data << w_shift) & w_mask);
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Purpose  : Single-outstanding load/store unit with big-endian sub-word
//            access and read-modify-write for byte/half stores.
// Revision : 1.0
// ============================================================================
module load_store_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_word_in,
    input  logic [31:0] mem_word_out
);
    import lsu_pkg::*;

    lsu_state_t  r_state;
    logic        r_write;
    logic        r_unsigned;
    logic [1:0]  r_size;
    logic [31:0] r_addr;
    logic [31:0] r_word;
    logic        r_resp_valid;
    logic        r_resp_error;
    logic [31:0] r_resp_rdata;

    logic [31:0] w_load_data;
    logic [31:0] w_merged_word;

    lsu_align u_align (
        .size        (r_size),
        .is_unsigned (r_unsigned),
        .offset      (r_addr[1:0]),
        .mem_word    (mem_word_out),
        .store_data  (r_word),
        .load_data   (w_load_data),
        .merged_word (w_merged_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_write      <= 1'b0;
            r_unsigned   <= 1'b0;
            r_size       <= SIZE_BYTE;
            r_addr       <= 32'h0;
            r_word       <= 32'h0;
            r_resp_valid <= 1'b0;
            r_resp_error <= 1'b0;
            r_resp_rdata <= 32'h0;
        end else begin
            r_resp_valid <= 1'b0;
            r_resp_error <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_write    <= req_write;
                        r_unsigned <= req_unsigned;
                        r_size     <= req_size;
                        r_addr     <= req_addr;
                        r_word     <= req_wdata;
                        if (req_is_illegal(req_size, req_addr[1:0])) begin
                            r_state      <= ST_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_error <= 1'b1;
                        end else if (req_write && (req_size == SIZE_WORD)) begin
                            r_state <= ST_WR;
                        end else begin
                            r_state <= ST_RD;
                        end
                    end
                end
                ST_RD: r_state <= ST_LATCH;
                ST_LATCH: begin
                    // Memory data is valid this cycle; stores merge into it, loads extract.
                    if (r_write) begin
                        r_word  <= w_merged_word;
                        r_state <= ST_WR;
                    end else begin
                        r_resp_rdata <= w_load_data;
                        r_resp_valid <= 1'b1;
                        r_state      <= ST_RESP;
                    end
                end
                ST_WR: begin
                    r_resp_valid <= 1'b1;
                    r_state      <= ST_RESP;
                end
                ST_RESP: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Strobes are gated by reset so an aborted request never touches memory.
    assign mem_read    = (r_state == ST_RD) && !rst;
    assign mem_write   = (r_state == ST_WR) && !rst;
    assign mem_address = {r_addr[31:2], 2'b00};
    assign mem_word_in = r_word;
    assign req_ready   = (r_state == ST_IDLE);
    assign resp_valid  = r_resp_valid;
    assign resp_error  = r_resp_error;
    assign resp_rdata  = r_resp_rdata;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_store_unit
// Purpose  : Directed self-checking bench for load_store_unit with a
//            one-cycle-latency word memory model.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_word_in;
    logic [31:0] mem_word_out;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem [0:255];
    logic [31:0] rd_q = 32'h0;
    logic        mem_init;
    int rd_cnt = 0, wr_cnt = 0, resp_cnt = 0, both_cnt = 0;

    load_store_unit dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_error   (resp_error),
        .mem_address  (mem_address),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_word_in  (mem_word_in),
        .mem_word_out (mem_word_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_init) begin
            mem[100] <= 32'h80FF7F01;
            mem[101] <= 32'h11223344;
        end else if (mem_write) begin
            mem[mem_address[9:2]] <= mem_word_in;
        end
        if (mem_read)               rd_q     <= mem[mem_address[9:2]];
        if (mem_read)               rd_cnt   <= rd_cnt + 1;
        if (mem_write)              wr_cnt   <= wr_cnt + 1;
        if (mem_read && mem_write)  both_cnt <= both_cnt + 1;
        if (resp_valid)             resp_cnt <= resp_cnt + 1;
    end
    assign mem_word_out = rd_q;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
    endtask

    // Issue one request, then measure cycles from the accept edge to resp_valid.
    task automatic do_req(input string tag, input logic w, input logic [1:0] sz,
                          input logic u, input logic [31:0] a, input logic [31:0] wd,
                          input int exp_lat, input logic exp_err, input logic [31:0] exp_rdata,
                          input int exp_rd, input int exp_wr);
        int lat;
        int rd0, wr0;
        wait_ready();
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        req_valid = 1'b1; req_write = w; req_size = sz;
        req_unsigned = u; req_addr = a; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"},   32'(lat),   32'(exp_lat));
        check({tag, "_err"},   {31'h0, resp_error}, {31'h0, exp_err});
        check({tag, "_rdata"}, resp_rdata, exp_rdata);
        @(posedge clk); #1;
        check({tag, "_reads"},  32'(rd_cnt - rd0), 32'(exp_rd));
        check({tag, "_writes"}, 32'(wr_cnt - wr0), 32'(exp_wr));
    endtask

    initial begin
        int lat;
        int r0, rd0, w0;

        rst = 1'b1; mem_init = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0; mem_init = 1'b0;
        check("rst_ready",      {31'h0, req_ready},  32'h1);
        check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        check("rst_resp_error", {31'h0, resp_error}, 32'h0);
        check("rst_rdata",      resp_rdata,          32'h0);
        check("rst_strobes",    {30'h0, mem_read, mem_write}, 32'h0);

        // Loads from 0x80FF7F01 at 400
        do_req("lb400",  1'b0, 2'b00, 1'b0, 32'd400, 32'h0, 3, 1'b0, 32'hFFFFFF80, 1, 0);
        do_req("lbu401", 1'b0, 2'b00, 1'b1, 32'd401, 32'h0, 3, 1'b0, 32'h000000FF, 1, 0);
        do_req("lh402",  1'b0, 2'b01, 1'b0, 32'd402, 32'h0, 3, 1'b0, 32'h00007F01, 1, 0);
        do_req("lh400",  1'b0, 2'b01, 1'b0, 32'd400, 32'h0, 3, 1'b0, 32'hFFFF80FF, 1, 0);
        do_req("lhu400", 1'b0, 2'b01, 1'b1, 32'd400, 32'h0, 3, 1'b0, 32'h000080FF, 1, 0);
        do_req("lw400",  1'b0, 2'b10, 1'b0, 32'd400, 32'h0, 3, 1'b0, 32'h80FF7F01, 1, 0);

        // Word store then read back; store leaves resp_rdata alone
        do_req("sw400",  1'b1, 2'b10, 1'b0, 32'd400, 32'hDEADBEEF, 2, 1'b0, 32'h80FF7F01, 0, 1);
        check("sw400_mem", mem[100], 32'hDEADBEEF);
        do_req("lw400b", 1'b0, 2'b10, 1'b0, 32'd400, 32'h0, 3, 1'b0, 32'hDEADBEEF, 1, 0);

        // Sub-word read-modify-write stores into 0x11223344 at 404
        do_req("sb406",  1'b1, 2'b00, 1'b0, 32'd406, 32'h123456AA, 4, 1'b0, 32'hDEADBEEF, 1, 1);
        check("sb406_mem", mem[101], 32'h1122AA44);
        do_req("sh404",  1'b1, 2'b01, 1'b0, 32'd404, 32'hFFFFBBCC, 4, 1'b0, 32'hDEADBEEF, 1, 1);
        check("sh404_mem", mem[101], 32'hBBCCAA44);

        // Illegal requests
        do_req("lh401",   1'b0, 2'b01, 1'b0, 32'd401, 32'h0, 1, 1'b1, 32'hDEADBEEF, 0, 0);
        do_req("lw402",   1'b0, 2'b10, 1'b0, 32'd402, 32'h0, 1, 1'b1, 32'hDEADBEEF, 0, 0);
        do_req("rsvd400", 1'b1, 2'b11, 1'b0, 32'd400, 32'h0, 1, 1'b1, 32'hDEADBEEF, 0, 0);
        check("err_mem100", mem[100], 32'hDEADBEEF);
        check("err_mem101", mem[101], 32'hBBCCAA44);

        // Reset asserted while a byte store sits in WR
        wait_ready();
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'd407; req_wdata = 32'h00000055;
        @(posedge clk); #1;
        req_valid = 1'b0;
        r0 = resp_cnt;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rstwr_wr_state", {31'h0, mem_write}, 32'h1);
        w0 = wr_cnt;
        rst = 1'b1;
        #1;
        check("rstwr_gated", {31'h0, mem_write}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        check("rstwr_ready", {31'h0, req_ready}, 32'h1);
        check("rstwr_no_resp", {31'h0, resp_valid}, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        check("rstwr_writes", 32'(wr_cnt - w0), 32'h0);
        check("rstwr_resps",  32'(resp_cnt - r0), 32'h0);
        check("rstwr_mem",    mem[101], 32'hBBCCAA44);
        check("rstwr_rdata",  resp_rdata, 32'h0);

        // Back-to-back loads with req_valid held high throughout
        wait_ready();
        r0 = resp_cnt;
        rd0 = rd_cnt;
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10;
        req_unsigned = 1'b0; req_addr = 32'd400;
        @(posedge clk); #1;
        req_size = 2'b00; req_unsigned = 1'b1; req_addr = 32'd403;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("b2b_first_lat",   32'(lat), 32'd3);
        check("b2b_first_rdata", resp_rdata, 32'hDEADBEEF);
        check("b2b_resp_busy",   {31'h0, req_ready}, 32'h0);
        @(posedge clk); #1;
        check("b2b_idle_ready",  {31'h0, req_ready}, 32'h1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("b2b_accepted",    {31'h0, req_ready}, 32'h0);
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("b2b_second_lat",   32'(lat), 32'd3);
        check("b2b_second_rdata", resp_rdata, 32'h000000EF);
        repeat (4) @(posedge clk);
        #1;
        check("b2b_resps", 32'(resp_cnt - r0), 32'd2);
        check("b2b_reads", 32'(rd_cnt - rd0), 32'd2);
        check("never_both_strobes", 32'(both_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 clk  in  1  single clock; all state updates on its rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 req_valid  in  1  request present.
REQ-004 req_ready  out  1  unit can accept a request; high only in IDLE.
REQ-005 req_write  in  1  1 = store, 0 = load.
REQ-006 req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-007 req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend.
REQ-008 req_addr  in  32  byte address.
REQ-009 req_wdata  in  32  store data, right-justified for byte/half.
REQ-010 resp_valid  out  1  one-cycle completion pulse.
REQ-011 resp_rdata  out  32  load result, held until next response.
REQ-012 resp_error  out  1  misaligned or reserved-size request, valid with resp_valid.
REQ-013 mem_address  out  32  word address to the data memory, always {addr[31:2],2'b00}.
REQ-014 mem_read  out  1  memory read strobe.
REQ-015 mem_write  out  1  memory write strobe.
REQ-016 mem_word_in  out  32  word written to memory.
REQ-017 mem_word_out  in  32  memory read data, valid the cycle after the edge that sampled mem_read=1.

Function
REQ-018 Accept SHALL occur on an edge with req_valid=1 and req_ready=1; the request fields SHALL be captured and cannot change afterwards.
REQ-019 States SHALL be IDLE, RD, LATCH, WR, RESP; RESP lasts exactly one cycle and returns to IDLE.
REQ-020 Transition paths SHALL be: load IDLE-RD-LATCH-RESP; word store IDLE-WR-RESP; byte/half store IDLE-RD-LATCH-WR-RESP (read-modify-write); error IDLE-RESP.
REQ-021 resp_valid SHALL be high in the cycle after accept edge +N: N=3 load, 2 word store, 4 sub-word store, 1 error.
REQ-022 mem_read SHALL be 1 only in RD; mem_write SHALL be 1 only in WR; both SHALL never be 1 in the same cycle.
REQ-023 Byte ordering SHALL be big-endian: offset addr[1:0]=0 selects bits 31:24, 3 selects 7:0; half offset 0 selects 31:16, offset 2 selects 15:0.
REQ-024 LATCH SHALL register mem_word_out; loads extract and extend the selected field into resp_rdata; sub-word stores merge req_wdata low bits into the selected field, leaving other bytes unchanged.
REQ-025 Misaligned requests (half with addr[0]=1, word with addr[1:0]!=0) and size 11 SHALL raise resp_error=1, perform no memory access, and leave resp_rdata unchanged.
REQ-026 Stores SHALL leave resp_rdata unchanged; resp_error=0 on all legal requests.
REQ-027 req_valid while not ready SHALL be ignored; the requester holds the request.

Reset
REQ-028 With rst=1, state SHALL go to IDLE at the edge; resp_valid, resp_error and resp_rdata SHALL be 0 and req_ready SHALL be 1 afterwards.
REQ-029 mem_read and mem_write SHALL be gated by !rst, so a reset arriving in RD or WR issues no memory access on that edge; the aborted request produces no response.

Structure
REQ-030 Shared package lsu_pkg SHALL hold the state enum and the size codes (SIZE_BYTE, SIZE_HALF, SIZE_WORD).
REQ-031 Sub-module lsu_align (combinational) SHALL provide load extraction/extension and store merging; the FSM, handshake and registers SHALL stay in load_store_unit.

Verification
REQ-032 Memory word at 400 = 0x80FF7F01: lb at 400 -> 0xFFFFFF80; lbu at 401 -> 0x000000FF; lh at 402 -> 0x00007F01; lw at 400 -> 0x80FF7F01; each response 3 cycles after accept.
REQ-033 sw 0xDEADBEEF at 400, then lw 400 -> 0xDEADBEEF; store response 2 cycles after accept; mem_read=0 throughout the store.
REQ-034 Word 0x11223344 at 404; sb 0xAA at 406 -> word 0x1122AA44; sh 0xBBCC at 404 -> 0xBBCCAA44; each store response 4 cycles after accept.
REQ-035 lh at 401, lw at 402, size 11 at 400 -> resp_error=1 after 1 cycle; mem_read and mem_write stay 0; memory contents unchanged.
REQ-036 Assert rst during WR of a sub-word store -> no memory write, no resp_valid; req_ready=1 the next cycle; word at target address unchanged.
REQ-037 Hold req_valid=1 with back-to-back loads -> the second is accepted only on the edge after RESP; no request is lost or duplicated.
